// File: rtl/pc_test_monitor_pkg.sv
// Shared types and helpers for the riscv-tests PC monitor.
// States, result codes and a width helper used by the monitor, its match unit and its interface.
package pc_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TIMEOUT,
        HANG
    } mon_state_t;

    typedef enum logic [1:0] {
        RES_PASS,
        RES_FAIL,
        RES_TIMEOUT,
        RES_HANG
    } mon_result_t;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_NUM_FAIL    = 4;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_STALL_LIMIT = 64;

    // A single fail slot still needs a one-bit index port.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_test_monitor_if.sv
// Bundle of the monitor's stimulus, configuration and result signals.
// The master modport drives the PC stream and settings; the slave modport is the monitor side.
interface pc_test_monitor_if #(
    parameter int XLEN     = 32,
    parameter int NUM_FAIL = 4,
    parameter int CNT_W    = 24
) ();
    import pc_mon_pkg::*;

    localparam int IDX_W = idxWidth(NUM_FAIL);

    logic                     start;
    logic                     pc_valid;
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          pass_addr;
    logic [XLEN-1:0]          last_addr;
    logic                     last_en;
    logic [NUM_FAIL*XLEN-1:0] fail_addr;
    logic [NUM_FAIL-1:0]      fail_en;
    logic [CNT_W-1:0]         cycle_limit;

    logic                     busy;
    logic                     done;
    logic [1:0]               result;
    logic [IDX_W-1:0]         fail_idx;
    logic [CNT_W-1:0]         cycles;

    modport master (
        output start, pc_valid, pc, pass_addr, last_addr, last_en,
               fail_addr, fail_en, cycle_limit,
        input  busy, done, result, fail_idx, cycles
    );

    modport slave (
        input  start, pc_valid, pc, pass_addr, last_addr, last_en,
               fail_addr, fail_en, cycle_limit,
        output busy, done, result, fail_idx, cycles
    );

endinterface

// File: rtl/pc_test_monitor_addr_match.sv
// Fail-address comparator bank with a lowest-index-wins priority encoder.
module pc_addr_match
    import pc_mon_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_FAIL = 4,
    parameter int IDX_W    = 2
) (
    input  logic [XLEN-1:0]          i_pc,
    input  logic [NUM_FAIL*XLEN-1:0] i_addr,
    input  logic [NUM_FAIL-1:0]      i_en,
    output logic                     o_hit,
    output logic [IDX_W-1:0]         o_idx
);

    logic [NUM_FAIL-1:0] w_eq;

    genvar g;
    generate
        for (g = 0; g < NUM_FAIL; g++) begin : g_cmp
            assign w_eq[g] = i_en[g] && (i_pc == i_addr[g*XLEN +: XLEN]);
        end
    endgenerate

    // Scan from the top slot down so the lowest matching slot is the one left standing.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_FAIL - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pc_test_monitor.sv
// Pass/fail/timeout/hang monitor for a committed PC stream of a riscv-tests run.
// Holds the run FSM, cycle and stall counters and the previous sampled PC; all outputs registered.
module pc_test_monitor
    import pc_mon_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int NUM_FAIL    = DEF_NUM_FAIL,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    pc_test_monitor_if.slave mon
);

    localparam int               IDX_W       = idxWidth(NUM_FAIL);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W:0]   STALL_LIM_W = (CNT_W + 1)'(STALL_LIMIT);
    localparam logic [CNT_W:0]   ONE_W       = (CNT_W + 1)'(1);

    mon_state_t       r_state;
    mon_state_t       w_stateNext;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] w_cyclesNext;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] w_stallNext;
    logic [XLEN-1:0]  r_prevPc;
    logic [XLEN-1:0]  w_prevPcNext;
    logic             r_prevVld;
    logic             w_prevVldNext;

    logic             r_busy;
    logic             r_done;
    mon_result_t      r_result;
    mon_result_t      w_resultNext;
    logic [IDX_W-1:0] r_failIdx;
    logic [IDX_W-1:0] w_failIdxNext;
    logic             w_busyNext;
    logic             w_doneNext;

    logic             w_failMatch;
    logic [IDX_W-1:0] w_failIdx;
    logic             w_sample;
    logic             w_samePc;
    logic [CNT_W-1:0] w_stallSample;
    logic [CNT_W-1:0] w_cyclesInc;
    logic [CNT_W:0]   w_cyclesPlusOne;
    logic             w_passHit;
    logic             w_failHit;
    logic             w_hangHit;
    logic             w_timeoutHit;

    pc_addr_match #(
        .XLEN     (XLEN),
        .NUM_FAIL (NUM_FAIL),
        .IDX_W    (IDX_W)
    ) u_match (
        .i_pc   (mon.pc),
        .i_addr (mon.fail_addr),
        .i_en   (mon.fail_en),
        .o_hit  (w_failMatch),
        .o_idx  (w_failIdx)
    );

    assign w_sample      = mon.pc_valid;
    assign w_samePc      = r_prevVld && (mon.pc == r_prevPc);
    assign w_stallSample = w_samePc ? (r_stall + 1'b1) : '0;

    // The stall count excludes the first sample of a streak, so the streak length is one more.
    assign w_hangHit = w_sample && (({1'b0, w_stallSample} + ONE_W) >= STALL_LIM_W);

    assign w_passHit = w_sample && (mon.pc == mon.pass_addr) &&
                       (!mon.last_en || (r_prevVld && (r_prevPc == mon.last_addr)));
    assign w_failHit = w_sample && w_failMatch;

    // Compared one bit wider so a saturated counter cannot wrap past the limit.
    assign w_cyclesPlusOne = {1'b0, r_cycles} + ONE_W;
    assign w_cyclesInc     = (r_cycles == CNT_MAX) ? r_cycles : (r_cycles + 1'b1);
    assign w_timeoutHit    = (mon.cycle_limit != '0) &&
                             (w_cyclesPlusOne >= {1'b0, mon.cycle_limit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A start pulse restarts from any state; otherwise only RUN moves, with FAIL > PASS > HANG > TIMEOUT.
    always_comb begin
        w_stateNext   = r_state;
        w_cyclesNext  = r_cycles;
        w_stallNext   = r_stall;
        w_prevPcNext  = r_prevPc;
        w_prevVldNext = r_prevVld;
        w_resultNext  = r_result;
        w_failIdxNext = r_failIdx;

        if (mon.start) begin
            w_stateNext   = RUN;
            w_cyclesNext  = '0;
            w_stallNext   = '0;
            w_prevVldNext = 1'b0;
            w_resultNext  = RES_PASS;
            w_failIdxNext = '0;
        end else if (r_state == RUN) begin
            w_cyclesNext = w_cyclesInc;
            if (w_sample) begin
                w_stallNext   = w_stallSample;
                w_prevPcNext  = mon.pc;
                w_prevVldNext = 1'b1;
            end
            if (w_failHit) begin
                w_stateNext   = FAIL;
                w_resultNext  = RES_FAIL;
                w_failIdxNext = w_failIdx;
            end else if (w_passHit) begin
                w_stateNext  = PASS;
                w_resultNext = RES_PASS;
            end else if (w_hangHit) begin
                w_stateNext  = HANG;
                w_resultNext = RES_HANG;
            end else if (w_timeoutHit) begin
                w_stateNext  = TIMEOUT;
                w_resultNext = RES_TIMEOUT;
            end
        end

        w_busyNext = (w_stateNext == RUN);
        w_doneNext = (w_stateNext == PASS) || (w_stateNext == FAIL) ||
                     (w_stateNext == TIMEOUT) || (w_stateNext == HANG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles  <= '0;
            r_stall   <= '0;
            r_prevPc  <= '0;
            r_prevVld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= RES_PASS;
            r_failIdx <= '0;
        end else begin
            r_cycles  <= w_cyclesNext;
            r_stall   <= w_stallNext;
            r_prevPc  <= w_prevPcNext;
            r_prevVld <= w_prevVldNext;
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
            r_result  <= w_resultNext;
            r_failIdx <= w_failIdxNext;
        end
    end

    assign mon.busy     = r_busy;
    assign mon.done     = r_done;
    assign mon.result   = r_result;
    assign mon.fail_idx = r_failIdx;
    assign mon.cycles   = r_cycles;

endmodule

// File: tb/tb_pc_test_monitor.sv
// Self-checking bench for pc_test_monitor: directed scenarios plus randomized runs,
// compared every cycle against a sample-history model of the monitor's rules.
module tb_pc_test_monitor;

    localparam int     XLEN        = 32;
    localparam int     NUM_FAIL    = 4;
    localparam int     CNT_W       = 24;
    localparam int     STALL_LIMIT = 64;
    localparam longint CNT_MAX     = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pc_test_monitor_if #(.XLEN(XLEN), .NUM_FAIL(NUM_FAIL), .CNT_W(CNT_W)) mon ();

    pc_test_monitor #(
        .XLEN        (XLEN),
        .NUM_FAIL    (NUM_FAIL),
        .CNT_W       (CNT_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    int checkCount = 0;
    int passCount  = 0;
    bit cmpOn      = 1'b0;

    // Model state: run flags, result, elapsed cycles and the valid PC samples of the current run.
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    int          m_result  = 0;
    int          m_failIdx = 0;
    longint      m_cycles  = 0;
    logic [31:0] hist[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual %0d required %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit v, input logic [31:0] p);
        @(negedge clk);
        mon.start    = s;
        mon.pc_valid = v;
        mon.pc       = p;
    endtask

    task automatic setConfig(input logic [31:0] passA, input logic [31:0] lastA, input bit lastEn,
                             input logic [3:0] failEn, input logic [CNT_W-1:0] limit);
        mon.pass_addr   = passA;
        mon.last_addr   = lastA;
        mon.last_en     = lastEn;
        mon.fail_en     = failEn;
        mon.cycle_limit = limit;
    endtask

    task automatic modelFinish(input int res, input int idx);
        m_busy    = 1'b0;
        m_done    = 1'b1;
        m_result  = res;
        m_failIdx = idx;
    endtask

    // One clock of the monitor's rules, expressed over the history of valid samples.
    task automatic modelStep();
        longint cyc1;
        bit     failHit;
        bit     passHit;
        bit     hangHit;
        bit     toHit;
        int     fIdx;
        int     streak;
        cyc1    = m_cycles + 1;
        failHit = 1'b0;
        passHit = 1'b0;
        hangHit = 1'b0;
        fIdx    = 0;
        if (mon.pc_valid) begin
            for (int i = NUM_FAIL - 1; i >= 0; i--) begin
                if (mon.fail_en[i] && (mon.fail_addr[i*XLEN +: XLEN] == mon.pc)) begin
                    failHit = 1'b1;
                    fIdx    = i;
                end
            end
            passHit = (mon.pc == mon.pass_addr) &&
                      (!mon.last_en || ((hist.size() > 0) && (hist[hist.size()-1] == mon.last_addr)));
            streak = 1;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (hist[k] != mon.pc) break;
                streak++;
            end
            hangHit = (streak >= STALL_LIMIT);
            hist.push_back(mon.pc);
            if (hist.size() > 2 * STALL_LIMIT) void'(hist.pop_front());
        end
        toHit    = (mon.cycle_limit != 0) && (cyc1 >= longint'(mon.cycle_limit));
        m_cycles = (cyc1 > CNT_MAX) ? CNT_MAX : cyc1;
        if (failHit)      modelFinish(1, fIdx);
        else if (passHit) modelFinish(0, 0);
        else if (hangHit) modelFinish(3, 0);
        else if (toHit)   modelFinish(2, 0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_result  = 0;
            m_failIdx = 0;
            m_cycles  = 0;
            hist.delete();
        end else if (mon.start) begin
            m_busy    = 1'b1;
            m_done    = 1'b0;
            m_result  = 0;
            m_failIdx = 0;
            m_cycles  = 0;
            hist.delete();
        end else if (m_busy) begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("busy", longint'(mon.busy), longint'(m_busy));
            checkOutput("done", longint'(mon.done), longint'(m_done));
            checkOutput("cycles", longint'(mon.cycles), m_cycles);
            if (m_done) checkOutput("result", longint'(mon.result), longint'(m_result));
            if (m_done && (m_result == 1)) checkOutput("fail_idx", longint'(mon.fail_idx), longint'(m_failIdx));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] pickPc(input logic [31:0] lastPc, input bit stuck);
        if (stuck && ($urandom_range(0, 19) != 0)) return lastPc;
        case ($urandom_range(0, 9))
            0:       return 32'h288;
            1:       return 32'h28C;
            2:       return 32'h2A4;
            3:       return 32'h300;
            4, 5:    return lastPc;
            default: return 32'h1000 + 32'($urandom_range(0, 63)) * 4;
        endcase
    endfunction

    initial begin
        logic [31:0] rp;
        logic [31:0] slot;
        bit          stuck;
        mon.start     = 1'b0;
        mon.pc_valid  = 1'b0;
        mon.pc        = '0;
        mon.fail_addr = '0;
        setConfig(32'h2A4, 32'h28C, 1'b1, 4'b0000, '0);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", longint'(mon.busy), 0);
        checkOutput("reset_done", longint'(mon.done), 0);
        checkOutput("reset_result", longint'(mon.result), 0);
        checkOutput("reset_fail_idx", longint'(mon.fail_idx), 0);
        checkOutput("reset_cycles", longint'(mon.cycles), 0);
        rst   = 1'b0;
        cmpOn = 1'b1;
        applyStimulus(0, 1, 32'h2A4);
        applyStimulus(0, 0, 32'h0);
        checkOutput("idle_stays_idle", longint'(mon.busy), 0);

        $display("[TB] scenario 1: predecessor-qualified pass");
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h280);
        applyStimulus(0, 1, 32'h284);
        applyStimulus(0, 1, 32'h288);
        applyStimulus(0, 1, 32'h28C);
        applyStimulus(0, 1, 32'h2A4);
        checkOutput("s1_not_done_yet", longint'(mon.done), 0);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s1_done", longint'(mon.done), 1);
        checkOutput("s1_result_pass", longint'(mon.result), 0);
        checkOutput("s1_cycles", longint'(mon.cycles), 5);

        $display("[TB] scenario 2: wrong predecessor, then arrival-only");
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h288);
        applyStimulus(0, 1, 32'h290);
        applyStimulus(0, 1, 32'h2A4);
        repeat (3) applyStimulus(0, 0, 32'h0);
        checkOutput("s2_still_busy", longint'(mon.busy), 1);
        mon.last_en = 1'b0;
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h290);
        applyStimulus(0, 1, 32'h2A4);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s2_fallback_done", longint'(mon.done), 1);
        checkOutput("s2_fallback_pass", longint'(mon.result), 0);

        $display("[TB] scenario 3: fail slot priority");
        mon.fail_addr = {32'h300, 32'h300, 32'h300, 32'h500};
        setConfig(32'h2A4, 32'h28C, 1'b1, 4'b0110, '0);
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h2A0);
        applyStimulus(0, 1, 32'h300);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s3_result_fail", longint'(mon.result), 1);
        checkOutput("s3_fail_idx", longint'(mon.fail_idx), 1);

        $display("[TB] scenario 4: timeout and disabled timeout");
        setConfig(32'h2A4, 32'h28C, 1'b1, 4'b0000, 24'd2000);
        applyStimulus(1, 0, 32'h0);
        for (int i = 0; i < 2000; i++) applyStimulus(0, 1, 32'h10000 + 32'(i) * 4);
        checkOutput("s4_busy_before_limit", longint'(mon.busy), 1);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s4_result_timeout", longint'(mon.result), 2);
        checkOutput("s4_cycles_2000", longint'(mon.cycles), 2000);
        mon.cycle_limit = '0;
        applyStimulus(1, 0, 32'h0);
        for (int i = 0; i < 5000; i++) applyStimulus(0, 1, 32'h10000 + 32'(i) * 4);
        checkOutput("s4_no_limit_busy", longint'(mon.busy), 1);

        $display("[TB] scenario 5: hang with bubbles");
        applyStimulus(1, 0, 32'h0);
        for (int i = 1; i <= 64; i++) begin
            if ((i % 10) == 0) applyStimulus(0, 0, 32'h1F0);
            applyStimulus(0, 1, 32'h1F0);
        end
        checkOutput("s5_busy_after_63", longint'(mon.busy), 1);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s5_done", longint'(mon.done), 1);
        checkOutput("s5_result_hang", longint'(mon.result), 3);

        $display("[TB] scenario 6: coincident hits, reset, restart");
        mon.fail_addr = {32'h0, 32'h0, 32'h0, 32'h2A4};
        setConfig(32'h2A4, 32'h28C, 1'b0, 4'b0001, '0);
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h2A4);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s6_fail_over_pass", longint'(mon.result), 1);
        checkOutput("s6_fail_idx0", longint'(mon.fail_idx), 0);
        mon.fail_en = 4'b0000;
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h100);
        applyStimulus(0, 1, 32'h104);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("s6_rst_busy", longint'(mon.busy), 0);
        checkOutput("s6_rst_cycles", longint'(mon.cycles), 0);
        checkOutput("s6_rst_done", longint'(mon.done), 0);
        #1 rst = 1'b0;
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 1, 32'h2A4);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s6_pass", longint'(mon.done), 1);
        applyStimulus(1, 0, 32'h0);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s6_restart_busy", longint'(mon.busy), 1);
        checkOutput("s6_restart_cycles", longint'(mon.cycles), 0);
        applyStimulus(0, 0, 32'h0);
        checkOutput("s6_restart_counting", longint'(mon.cycles), 1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < NUM_FAIL; s++) begin
                case ($urandom_range(0, 3))
                    0:       slot = 32'h300;
                    1:       slot = 32'h2A4;
                    2:       slot = 32'h288;
                    default: slot = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                endcase
                mon.fail_addr[s*XLEN +: XLEN] = slot;
            end
            setConfig(32'h2A4, 32'h28C, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(20, 250)));
            stuck = ($urandom_range(0, 4) == 0);
            rp    = 32'h1F0;
            applyStimulus(1, 0, 32'h0);
            for (int c = 0; c < 300; c++) begin
                rp = pickPc(rp, stuck);
                applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rp);
                if (m_done) break;
            end
            applyStimulus(0, 0, 32'h0);
        end

        cmpOn = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
